uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 153 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Two-requester scheduler feeding a byte-wide UART transmitter: round-robin
// ownership, per-byte DATA_VALID handshake against TX_BUSY with timed retry.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no owner; arbitrate and capture the winner's data
//   SEND      | one-cycle TX_D_VALID pulse for the current byte
//   WAIT_BUSY | wait for TX_BUSY to rise; retry SEND on timeout
//   WAIT_DONE | transmitter busy; wait for TX_BUSY to fall
module uart_tx_sched #(
   parameter int DATA_WIDTH   = 8,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    ALU_OUT_VALID,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   output logic                    ALU_ACK,
   input  logic                    RD_DATA_VALID,
   input  logic [DATA_WIDTH-1:0]   RD_DATA,
   output logic                    RD_ACK,
   input  logic                    TX_BUSY,
   output logic [DATA_WIDTH-1:0]   TX_P_DATA,
   output logic                    TX_D_VALID,
   output logic [1:0]              GRANT
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

   localparam logic [1:0] G_NONE = 2'b00;
   localparam logic [1:0] G_ALU  = 2'b01;
   localparam logic [1:0] G_RD   = 2'b10;
   localparam logic [2:0] TO_TC  = 3'(BUSY_TIMEOUT - 1);

   state_t                  state_q, state_d;
   logic [2*DATA_WIDTH-1:0] buf_q, buf_d;
   logic [1:0]              byte_cnt_q, byte_cnt_d;
   logic [2:0]              to_cnt_q, to_cnt_d;
   logic [1:0]              last_g_q, last_g_d;
   logic [1:0]              grant_q, grant_d;
   logic                    ack_a_q, ack_a_d;
   logic                    ack_r_q, ack_r_d;
   logic                    dv_q, dv_d;
   logic [DATA_WIDTH-1:0]   pd_q, pd_d;
   logic                    pick_alu, pick_rd;
   logic [2:0]              to_cnt_inc;

   // On a tie the requester not served last wins
   assign pick_alu   = ALU_OUT_VALID && (!RD_DATA_VALID || (last_g_q == G_RD));
   assign pick_rd    = RD_DATA_VALID && !pick_alu;
   assign to_cnt_inc = (to_cnt_q == 3'd7) ? to_cnt_q : to_cnt_q + 3'd1;

   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      byte_cnt_d = byte_cnt_q;
      to_cnt_d   = to_cnt_q;
      last_g_d   = last_g_q;
      grant_d    = grant_q;
      pd_d       = pd_q;
      ack_a_d    = 1'b0;
      ack_r_d    = 1'b0;
      dv_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_alu) begin
               buf_d      = ALU_OUT;
               byte_cnt_d = 2'd2;
               grant_d    = G_ALU;
               ack_a_d    = 1'b1;
               pd_d       = ALU_OUT[DATA_WIDTH-1:0];
               dv_d       = 1'b1;
               to_cnt_d   = 3'd0;
               state_d    = SEND;
            end else if (pick_rd) begin
               buf_d      = {{DATA_WIDTH{1'b0}}, RD_DATA};
               byte_cnt_d = 2'd1;
               grant_d    = G_RD;
               ack_r_d    = 1'b1;
               pd_d       = RD_DATA;
               dv_d       = 1'b1;
               to_cnt_d   = 3'd0;
               state_d    = SEND;
            end
         end
         SEND: begin
            to_cnt_d = to_cnt_inc;
            state_d  = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (TX_BUSY) begin
               state_d = WAIT_DONE;
            end else if (to_cnt_q >= TO_TC) begin
               dv_d     = 1'b1;
               to_cnt_d = 3'd0;
               state_d  = SEND;
            end else begin
               to_cnt_d = to_cnt_inc;
            end
         end
         WAIT_DONE: begin
            if (!TX_BUSY) begin
               if (byte_cnt_q > 2'd1) begin
                  byte_cnt_d = byte_cnt_q - 2'd1;
                  pd_d       = buf_q[2*DATA_WIDTH-1:DATA_WIDTH];
                  dv_d       = 1'b1;
                  to_cnt_d   = 3'd0;
                  state_d    = SEND;
               end else begin
                  byte_cnt_d = 2'd0;
                  last_g_d   = grant_q;
                  grant_d    = G_NONE;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= IDLE;
         buf_q      <= '0;
         byte_cnt_q <= 2'd0;
         to_cnt_q   <= 3'd0;
         last_g_q   <= G_RD;
         grant_q    <= G_NONE;
         ack_a_q    <= 1'b0;
         ack_r_q    <= 1'b0;
         dv_q       <= 1'b0;
         pd_q       <= '0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         byte_cnt_q <= byte_cnt_d;
         to_cnt_q   <= to_cnt_d;
         last_g_q   <= last_g_d;
         grant_q    <= grant_d;
         ack_a_q    <= ack_a_d;
         ack_r_q    <= ack_r_d;
         dv_q       <= dv_d;
         pd_q       <= pd_d;
      end
   end

   assign ALU_ACK    = ack_a_q;
   assign RD_ACK     = ack_r_q;
   assign TX_D_VALID = dv_q;
   assign TX_P_DATA  = pd_q;
   assign GRANT      = grant_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: cycle-vector table plus hand sequences driven
// against a behavioural UART transmitter BUSY model.
module tb_uart_tx_sched;

   localparam int BUSY_TIMEOUT = 4;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        ALU_OUT_VALID = 1'b0;
   logic [15:0] ALU_OUT = '0;
   logic        ALU_ACK;
   logic        RD_DATA_VALID = 1'b0;
   logic [7:0]  RD_DATA = '0;
   logic        RD_ACK;
   logic        TX_BUSY;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VALID;
   logic [1:0]  GRANT;

   logic model_en = 1'b0;
   logic tbl_busy = 1'b0;
   logic mdl_busy = 1'b0;
   int   m_dly = 2, m_len = 10, ign_at = -1;
   int   seen_cnt = 0, start_left = 0, busy_left = 0;

   assign TX_BUSY = model_en ? mdl_busy : tbl_busy;

   uart_tx_sched #(.DATA_WIDTH(8), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
      .CLK(CLK), .RST(RST),
      .ALU_OUT_VALID(ALU_OUT_VALID), .ALU_OUT(ALU_OUT), .ALU_ACK(ALU_ACK),
      .RD_DATA_VALID(RD_DATA_VALID), .RD_DATA(RD_DATA), .RD_ACK(RD_ACK),
      .TX_BUSY(TX_BUSY), .TX_P_DATA(TX_P_DATA), .TX_D_VALID(TX_D_VALID),
      .GRANT(GRANT)
   );

   always #5 CLK = ~CLK;

   // Transmitter model: BUSY rises m_dly cycles after a DATA_VALID, for m_len cycles
   always @(negedge CLK) begin
      if (busy_left > 0) begin
         busy_left = busy_left - 1;
         if (busy_left == 0) mdl_busy = 1'b0;
      end
      if (start_left > 0) begin
         start_left = start_left - 1;
         if (start_left == 0) begin
            mdl_busy  = 1'b1;
            busy_left = m_len;
         end
      end
      if (TX_D_VALID) begin
         if (seen_cnt != ign_at) start_left = m_dly;
         seen_cnt = seen_cnt + 1;
      end
   end

   typedef struct {
      logic        rst, av;
      logic [15:0] a;
      logic        rv;
      logic [7:0]  r;
      logic        b;
      logic        aa, ar, dv;
      logic [7:0]  pd;
      logic [1:0]  g;
   } vec_t;
   vec_t vec[$];

   int nchk = 0, nerr = 0;
   int cyc, np, nack_a, nack_r, nboth, nord;
   int pcyc[8];
   logic [7:0] pbyte[8];
   int ord[8];
   logic seen_g10;
   logic [1:0] last_g;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic v(input logic rst, input logic av, input logic [15:0] a,
                    input logic rv, input logic [7:0] r, input logic b,
                    input logic aa, input logic ar, input logic dv,
                    input logic [7:0] pd, input logic [1:0] g);
      vec_t t;
      t.rst = rst; t.av = av; t.a = a; t.rv = rv; t.r = r; t.b = b;
      t.aa = aa; t.ar = ar; t.dv = dv; t.pd = pd; t.g = g;
      vec.push_back(t);
   endtask

   task automatic mon_clear();
      cyc = 0; np = 0; nack_a = 0; nack_r = 0; nboth = 0; nord = 0;
      seen_g10 = 1'b0; last_g = 2'b00;
   endtask

   task automatic mon(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK); #1;
         cyc++;
         if (TX_D_VALID && np < 8) begin
            pcyc[np] = cyc; pbyte[np] = TX_P_DATA; np++;
         end
         if (ALU_ACK) begin
            nack_a++;
            if (nord < 8) begin ord[nord] = 1; nord++; end
         end
         if (RD_ACK) begin
            nack_r++;
            if (nord < 8) begin ord[nord] = 2; nord++; end
         end
         if (ALU_ACK && RD_ACK) nboth++;
         if (GRANT == 2'b10) seen_g10 = 1'b1;
         last_g = GRANT;
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b0; ALU_OUT_VALID = 1'b0; RD_DATA_VALID = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //   rst av a        rv r      b   aa ar dv pd     g
      v(0, 0, 16'h0,    0, 8'h00, 0,  0, 0, 0, 8'h00, 2'd0);
      v(1, 0, 16'h0,    0, 8'h00, 0,  0, 0, 0, 8'h00, 2'd0);
      v(1, 0, 16'h0,    1, 8'hA5, 0,  0, 1, 1, 8'hA5, 2'd2);
      v(1, 0, 16'h0,    0, 8'h00, 0,  0, 0, 0, 8'hA5, 2'd2);
      v(1, 0, 16'h0,    0, 8'h00, 1,  0, 0, 0, 8'hA5, 2'd2);
      v(1, 0, 16'h0,    0, 8'h00, 1,  0, 0, 0, 8'hA5, 2'd2);
      v(1, 0, 16'h0,    0, 8'h00, 0,  0, 0, 0, 8'hA5, 2'd0);
      v(1, 1, 16'h1234, 0, 8'h00, 0,  1, 0, 1, 8'h34, 2'd1);
      v(1, 0, 16'h0,    1, 8'h5A, 0,  0, 0, 0, 8'h34, 2'd1);
      v(1, 0, 16'h0,    1, 8'h5A, 1,  0, 0, 0, 8'h34, 2'd1);
      v(1, 0, 16'h0,    1, 8'h5A, 0,  0, 0, 1, 8'h12, 2'd1);
      v(1, 0, 16'h0,    1, 8'h5A, 0,  0, 0, 0, 8'h12, 2'd1);
      v(1, 0, 16'h0,    1, 8'h5A, 1,  0, 0, 0, 8'h12, 2'd1);
      v(1, 0, 16'h0,    1, 8'h5A, 0,  0, 0, 0, 8'h12, 2'd0);
      v(1, 0, 16'h0,    1, 8'h5A, 0,  0, 1, 1, 8'h5A, 2'd2);
      v(1, 0, 16'h0,    0, 8'h00, 0,  0, 0, 0, 8'h5A, 2'd2);
      v(1, 1, 16'hBEEF, 0, 8'h00, 0,  0, 0, 0, 8'h5A, 2'd2);
      v(1, 0, 16'h0,    0, 8'h00, 0,  0, 0, 0, 8'h5A, 2'd2);
      v(1, 0, 16'h0,    0, 8'h00, 0,  0, 0, 1, 8'h5A, 2'd2);
      v(1, 0, 16'h0,    0, 8'h00, 0,  0, 0, 0, 8'h5A, 2'd2);
      v(1, 0, 16'h0,    0, 8'h00, 1,  0, 0, 0, 8'h5A, 2'd2);
      v(1, 0, 16'h0,    0, 8'h00, 0,  0, 0, 0, 8'h5A, 2'd0);
      v(1, 0, 16'h0,    0, 8'h00, 0,  0, 0, 0, 8'h5A, 2'd0);

      for (int k = 0; k < vec.size(); k++) begin
         @(negedge CLK);
         RST = vec[k].rst; ALU_OUT_VALID = vec[k].av; ALU_OUT = vec[k].a;
         RD_DATA_VALID = vec[k].rv; RD_DATA = vec[k].r; tbl_busy = vec[k].b;
         @(posedge CLK); #1;
         chk($sformatf("vec%0d", k), {19'd0, ALU_ACK, RD_ACK, TX_D_VALID, TX_P_DATA, GRANT},
             {19'd0, vec[k].aa, vec[k].ar, vec[k].dv, vec[k].pd, vec[k].g});
      end

      // Single RD byte, BUSY 2 cycles after DATA_VALID for 10 cycles
      model_en = 1'b1; m_dly = 2; m_len = 10;
      do_reset(); mon(20); mon_clear();
      @(negedge CLK); RD_DATA_VALID = 1'b1; RD_DATA = 8'hA5;
      mon(1);
      @(negedge CLK); RD_DATA_VALID = 1'b0;
      mon(30);
      chk("rd_ack_count", nack_r, 1);
      chk("rd_pulses", np, 1);
      chk("rd_byte", pbyte[0], 8'hA5);
      chk("rd_grant_seen", seen_g10, 1);
      chk("rd_grant_end", last_g, 0);
      chk("rd_no_alu_ack", nack_a, 0);

      // ALU word: two bytes, second only after BUSY falls
      do_reset(); mon(20); mon_clear();
      @(negedge CLK); ALU_OUT_VALID = 1'b1; ALU_OUT = 16'h1234;
      mon(1);
      @(negedge CLK); ALU_OUT_VALID = 1'b0;
      mon(40);
      chk("alu_pulses", np, 2);
      chk("alu_byte0", pbyte[0], 8'h34);
      chk("alu_byte1", pbyte[1], 8'h12);
      chk("alu_gap", pcyc[1] - pcyc[0], 13);
      chk("alu_ack_count", nack_a, 1);
      chk("alu_grant_end", last_g, 0);

      // Round robin with both requesters continuously re-requesting
      m_dly = 1; m_len = 2;
      do_reset(); mon(20); mon_clear();
      @(negedge CLK);
      ALU_OUT_VALID = 1'b1; ALU_OUT = 16'h00C3; RD_DATA_VALID = 1'b1; RD_DATA = 8'h7E;
      for (int i = 0; i < 200 && nord < 4; i++) mon(1);
      chk("rr_ack_total", nord, 4);
      chk("rr_order", {ord[0][3:0], ord[1][3:0], ord[2][3:0], ord[3][3:0]}, 16'h1212);
      chk("rr_ack_overlap", nboth, 0);
      @(negedge CLK); ALU_OUT_VALID = 1'b0; RD_DATA_VALID = 1'b0;
      mon(20);

      // Transmitter ignores the first DATA_VALID -> timed retry
      m_dly = 2; m_len = 3;
      do_reset(); mon(20); mon_clear();
      @(negedge CLK); ign_at = seen_cnt; RD_DATA_VALID = 1'b1; RD_DATA = 8'h3C;
      mon(1);
      @(negedge CLK); RD_DATA_VALID = 1'b0;
      mon(30);
      chk("retry_pulses", np, 2);
      chk("retry_gap", pcyc[1] - pcyc[0], BUSY_TIMEOUT);
      chk("retry_byte0", pbyte[0], 8'h3C);
      chk("retry_byte1", pbyte[1], 8'h3C);
      chk("retry_ack_count", nack_r, 1);

      // Reset while the ALU's first byte is in WAIT_DONE
      m_dly = 2; m_len = 10;
      do_reset(); mon(20); mon_clear();
      @(negedge CLK); ALU_OUT_VALID = 1'b1; ALU_OUT = 16'h1234;
      mon(1);
      @(negedge CLK); ALU_OUT_VALID = 1'b0;
      mon(4);
      chk("rst_pre_pulses", np, 1);
      @(negedge CLK); RST = 1'b0;
      @(posedge CLK); #1;
      chk("rst_outputs", {ALU_ACK, RD_ACK, TX_D_VALID, TX_P_DATA, GRANT}, 13'd0);
      @(negedge CLK); RST = 1'b1;
      mon_clear();
      mon(30);
      chk("rst_no_pulse", np, 0);
      chk("rst_no_reack", nack_a + nack_r, 0);
      chk("rst_grant", last_g, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
